// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
//
// Purpose:
//   Loads a program image from a valid/ready word source into the processor's
//   program memory. A load holds the processor in clear, takes the memory port
//   away from the processor, streams len words to addresses 0..len-1, releases
//   the memory port for one cycle with the processor still cleared, and then
//   lets the processor run.
//
// Ports:
//   clk       - single clock, all state updates on its rising edge
//   clr       - asynchronous active-low reset
//   start     - single-cycle load request (honoured only in IDLE and RUN)
//   len       - number of words to load, sampled with start
//   in_valid  - source presents a word on in_data
//   in_data   - instruction word from the source
//   in_ready  - loader accepts a word this cycle (LOAD only)
//   mem_sel   - loader owns the memory port (external address/data mux select)
//   mem_addr  - memory write address (0 outside LOAD)
//   mem_din   - memory write data (0 outside LOAD)
//   mem_we    - memory write enable (LOAD only)
//   cpu_clr   - active-high clear to the processor
//   cpu_ce    - processor control-unit enable
//   busy      - high in CLEAR, LOAD and RELEASE
//   done      - one-cycle pulse in the first RUN cycle
//   err       - one-cycle pulse in the cycle after a rejected start
// ----------------------------------------------------------------------------
module prog_loader #(
   parameter int DEPTH      = 256,
   parameter int CLR_CYCLES = 4
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [8:0]  len,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        mem_sel,
   output logic [7:0]  mem_addr,
   output logic [15:0] mem_din,
   output logic        mem_we,
   output logic        cpu_clr,
   output logic        cpu_ce,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      RELEASE,
      RUN
   } state_t;

   state_t        state;
   state_t        next_state;

   logic [8:0]    len_q;
   logic [8:0]    word_cnt;
   logic [7:0]    wr_ptr;
   logic [CW-1:0] clr_cnt;
   logic          done_q;
   logic          err_q;

   logic          start_cmd;
   logic          len_ok;
   logic          start_ok;
   logic          start_bad;
   logic          clr_last;
   logic          word_acc;
   logic          last_word;

   // A start only means something when no load is in progress; the length
   // check is the same from IDLE and from RUN.
   assign start_cmd = start && ((state == IDLE) || (state == RUN));
   assign len_ok    = (32'(len) <= DEPTH);
   assign start_ok  = start_cmd && len_ok;
   assign start_bad = start_cmd && !len_ok;

   // The clear counter starts at zero on entry, so the last CLEAR cycle is
   // the one where it reads CLR_CYCLES-1.
   assign clr_last  = (clr_cnt == CW'(CLR_CYCLES - 1));

   // in_ready is constantly high in LOAD, so in_valid alone marks an accepted
   // word. word_cnt is 9 bits so a 256-word load can recognise its last word
   // even though wr_ptr wraps back to zero after address 255.
   assign word_acc  = (state == LOAD) && in_valid;
   assign last_word = word_acc && (word_cnt == (len_q - 9'd1));

   // State register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A zero-length load skips LOAD entirely once the clear
   // period has elapsed.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start_ok) next_state = CLEAR;
         end
         CLEAR: begin
            if (clr_last) next_state = (len_q == 9'd0) ? RELEASE : LOAD;
         end
         LOAD: begin
            if (last_word) next_state = RELEASE;
         end
         RELEASE: begin
            next_state = RUN;
         end
         RUN: begin
            if (start_ok) next_state = CLEAR;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath registers: latched length, clear counter, write pointer, word
   // counter, and the registered done/err pulses. done is raised for the cycle
   // after RELEASE, i.e. the first RUN cycle; err follows a rejected start by
   // one cycle so that reset can always force it low.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         len_q    <= '0;
         word_cnt <= '0;
         wr_ptr   <= '0;
         clr_cnt  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= (state == RELEASE);
         err_q  <= start_bad;
         if (start_ok) begin
            len_q    <= len;
            clr_cnt  <= '0;
            wr_ptr   <= '0;
            word_cnt <= '0;
         end else if ((state == CLEAR) && !clr_last) begin
            clr_cnt <= clr_cnt + CW'(1);
         end else if (word_acc) begin
            wr_ptr   <= wr_ptr + 8'd1;
            word_cnt <= word_cnt + 9'd1;
         end
      end
   end

   // Output decode. The defaults are the idle/reset values: processor held in
   // clear, memory port handed back to the processor, address and data
   // buses parked at zero.
   always_comb begin
      in_ready = 1'b0;
      mem_sel  = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      mem_we   = 1'b0;
      cpu_clr  = 1'b1;
      cpu_ce   = 1'b0;
      busy     = 1'b0;
      case (state)
         CLEAR: begin
            mem_sel = 1'b1;
            busy    = 1'b1;
         end
         LOAD: begin
            mem_sel  = 1'b1;
            busy     = 1'b1;
            in_ready = 1'b1;
            mem_addr = wr_ptr;
            mem_din  = in_data;
            mem_we   = in_valid;
         end
         RELEASE: begin
            busy = 1'b1;
         end
         RUN: begin
            cpu_clr = 1'b0;
            cpu_ce  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign done = done_q;
   assign err  = err_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256; number of 16-bit words in the program memory.
REQ-002 SHALL have parameter CLR_CYCLES, default 4; number of cycles the processor is held cleared before loading.
REQ-003 SHALL have port clk, input, 1; the single clock, and all state SHALL update on its rising edge.
REQ-004 SHALL have port clr, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1; single-cycle load request.
REQ-006 SHALL have port len, input, 9; number of words to load, sampled on the start cycle.
REQ-007 SHALL have port in_valid, input, 1; the source has a word on in_data.
REQ-008 SHALL have port in_data, input, 16; instruction word from the source.
REQ-009 SHALL have port in_ready, output, 1; the loader accepts a word this cycle.
REQ-010 SHALL have port mem_sel, output, 1; 1 means the loader owns the memory port (external address/data mux select).
REQ-011 SHALL have port mem_addr, output, 8; memory write address.
REQ-012 SHALL have port mem_din, output, 16; memory write data.
REQ-013 SHALL have port mem_we, output, 1; memory write enable.
REQ-014 SHALL have port cpu_clr, output, 1; active-high clear to the processor.
REQ-015 SHALL have port cpu_ce, output, 1; processor control-unit enable.
REQ-016 SHALL have port busy, output, 1; high in CLEAR, LOAD and RELEASE.
REQ-017 SHALL have port done, output, 1; one-cycle pulse on entry to RUN.
REQ-018 SHALL have port err, output, 1; one-cycle pulse when a start is rejected.

Function
REQ-019 SHALL implement states IDLE, CLEAR, LOAD, RELEASE and RUN.
REQ-020 IDLE: start with len<=DEPTH SHALL latch len, zero the clear counter and the write pointer, and go to CLEAR; start with len>DEPTH SHALL pulse err for one cycle and stay in IDLE.
REQ-021 CLEAR: cpu_clr=1, cpu_ce=0, mem_sel=1; after exactly CLR_CYCLES cycles in CLEAR, go to LOAD, or go straight to RELEASE if the latched len=0.
REQ-022 LOAD: in_ready=1; mem_addr=wr_ptr and mem_din=in_data combinationally; mem_we=in_valid&in_ready.
REQ-023 LOAD: each accepted word (in_valid=1 in LOAD) SHALL increment wr_ptr by 1 and count it; the cycle that accepts word number len SHALL be the final write and go to RELEASE.
REQ-024 LOAD: in_valid=0 SHALL stall indefinitely with no write and no pointer change.
REQ-025 wr_ptr SHALL be 8 bits, and a load of 256 words SHALL write addresses 0..255 with no extra write after address 255.
REQ-026 RELEASE: lasts one cycle; cpu_clr=1, mem_sel=0, mem_we=0, in_ready=0; then go to RUN and pulse done.
REQ-027 RUN: cpu_clr=0, cpu_ce=1, mem_sel=0, busy=0; in_ready=0.
REQ-028 RUN: a start SHALL apply the same len check as IDLE; if accepted, go to CLEAR (processor re-cleared, cpu_ce=0 next cycle).
REQ-029 start asserted in CLEAR, LOAD or RELEASE SHALL be ignored (no err).
REQ-030 mem_we SHALL never be 1 outside LOAD.
REQ-031 mem_addr and mem_din SHALL be 0 outside LOAD.

Reset
REQ-032 clr=0 SHALL immediately, without waiting for clk, force IDLE, wr_ptr=0, clear counter=0, cpu_clr=1, cpu_ce=0, mem_sel=0, mem_we=0, in_ready=0, mem_addr=0, mem_din=0, busy=0, done=0, err=0.
REQ-033 clr asserted mid-LOAD SHALL abandon the load with no further writes; words already written stay in memory.
REQ-034 After clr deasserts, the block SHALL stay in IDLE until the next start.

Verification
REQ-035 Basic load: len=3, start, words 0x1234/0x5678/0x9ABC back-to-back -> CLEAR for 4 cycles; mem_we on 3 consecutive cycles at addr 0,1,2; 1 RELEASE cycle; done pulse; cpu_ce=1, cpu_clr=0.
REQ-036 Stall: len=2, in_valid low for 5 cycles between the two words -> no writes while stalled; 2nd word at addr 1; done only after the 2nd word.
REQ-037 Bounds: len=256 streamed -> last write at addr 255, 256 writes total; then len=257 start in RUN -> err pulse, cpu_ce stays 1; len=0 -> CLEAR, RELEASE, RUN with zero writes.
REQ-038 Restart: start with len=1 while in RUN -> cpu_ce=0 and cpu_clr=1 next cycle; one write at addr 0; back to RUN.
REQ-039 Reset mid-load: clr=0 asynchronously after 2 of 5 words -> outputs at reset values before the next edge; no write to addr 2; IDLE after release.
REQ-040 Ignored start: start pulses during CLEAR and LOAD -> no effect on state, counter or err.
